// File: rtl/arm_control.sv
// Fetch/sequencing stage of the non-pipelined Harvard CPU: owns the program
// counter and instruction register and emits the one-hot state vector.
module arm_control #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            zero_flag,
  output logic [15:0]     inst,
  output logic [2:0]      state,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  localparam logic [3:0] OP_B    = 4'b0000;
  localparam logic [3:0] OP_BZ   = 4'b0001;
  localparam logic [3:0] OP_HALT = 4'b0100;
  localparam logic [3:0] OP_LDR  = 4'b1110;

  typedef enum logic [2:0] {
    S_HALT  = 3'b000,
    S_FETCH = 3'b001,
    S_EXEC1 = 3'b010,
    S_EXEC2 = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     inst_q, inst_d;
  logic            halted_q, halted_d;
  logic [3:0]      opcode;

  // Branch target relative to the already-incremented pc; the 12-bit offset
  // is sign-extended and any bits above PC_W fall away, so wrap is modular.
  function automatic logic [PC_W-1:0] branch_target(
    input logic [PC_W-1:0] pc_in,
    input logic [11:0]     off
  );
    logic signed [15:0] off_ext;
    off_ext = {{4{off[11]}}, off};
    return pc_in + off_ext[PC_W-1:0];
  endfunction

  assign opcode = inst_q[15:12];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_data;
          pc_d    = pc_q + 1'b1;
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        state_d = S_FETCH;
        if (opcode == OP_LDR) begin
          state_d = S_EXEC2;
        end else if (!opcode[3]) begin
          case (opcode)
            OP_B:    pc_d = branch_target(pc_q, inst_q[11:0]);
            OP_BZ:   if (zero_flag) pc_d = branch_target(pc_q, inst_q[11:0]);
            OP_HALT: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_EXEC2: begin
        if (dmem_ready) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      // Any non-one-hot encoding falls back to a clean fetch.
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RST_PC;
      inst_q   <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign state     = state_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_arm_control.sv
// Bench for arm_control: directed scenarios plus random instruction streams,
// all checked against an arithmetic reference model of the fetch sequencer.
module tb_arm_control;

  localparam int PC_W     = 8;
  localparam int RESET_PC = 0;
  localparam int PC_MOD   = 1 << PC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data = 16'h0000;
  logic            imem_ready = 1'b0;
  logic            dmem_ready = 1'b0;
  logic            zero_flag = 1'b0;
  logic [15:0]     inst;
  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic            halted;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0=fetch 1=exec1 2=exec2 3=halt.
  int          m_pc;
  int          m_ph;
  logic [15:0] m_inst;
  logic        m_halt;

  arm_control #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero_flag(zero_flag),
    .inst(inst), .state(state), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap_pc(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic logic [2:0] model_state();
    case (m_ph)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_step();
    int op, off;
    if (reset) begin
      m_pc = RESET_PC; m_inst = 16'h0000; m_ph = 0; m_halt = 1'b0;
    end else begin
      case (m_ph)
        0: if (imem_ready) begin
             m_inst = imem_data;
             m_pc   = wrap_pc(m_pc + 1);
             m_ph   = 1;
           end
        1: begin
             op  = int'(m_inst[15:12]);
             off = int'(m_inst[11:0]);
             if (off >= 2048) off -= 4096;
             if (op == 14) m_ph = 2;
             else if (op == 4) begin m_ph = 3; m_halt = 1'b1; end
             else begin
               if (op == 0 || (op == 1 && zero_flag)) m_pc = wrap_pc(m_pc + off);
               m_ph = 0;
             end
           end
        2: if (dmem_ready) m_ph = 0;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare everything at the
  // falling edge against the model.
  task automatic step(input logic r, input logic ir, input logic [15:0] d,
                      input logic dr, input logic z);
    reset = r; imem_ready = ir; imem_data = d; dmem_ready = dr; zero_flag = z;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("state", 32'(state), 32'(model_state()));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("inst", 32'(inst), 32'(m_inst));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("imem_addr", 32'(imem_addr), 32'(pc));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int halt_cnt;
    logic r, ir, dr, z;
    logic [15:0] d;

    m_pc = 0; m_ph = 0; m_inst = 16'h0000; m_halt = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_pc", 32'(pc), RESET_PC);
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // ALU op
    step(1'b0, 1'b1, 16'h8123, 1'b0, 1'b0);
    chk("alu_state1", 32'(state), 32'h2);
    chk("alu_pc", 32'(pc), 32'h1);
    chk("alu_inst", 32'(inst), 32'h8123);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("alu_state2", 32'(state), 32'h1);

    // LDR with two dmem wait cycles
    do_reset();
    step(1'b0, 1'b1, 16'hE045, 1'b0, 1'b0);
    chk("ldr_exec1", 32'(state), 32'h2);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ldr_exec2a", 32'(state), 32'h4);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ldr_exec2c", 32'(state), 32'h4);
    chk("ldr_pc", 32'(pc), 32'h1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("ldr_done", 32'(state), 32'h1);

    // Backward branch from pc=5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 16'h2000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    chk("b_pre_pc", 32'(pc), 32'h5);
    step(1'b0, 1'b1, 16'h0FFE, 1'b0, 1'b0);
    chk("b_fetch_pc", 32'(pc), 32'h6);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("b_target", 32'(pc), 32'h4);

    // Wrap: reach 254 by a backward branch, then branch +1 from 255
    do_reset();
    step(1'b0, 1'b1, 16'h0FFD, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("wrap_back", 32'(pc), 32'd254);
    step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    chk("wrap_fetch", 32'(pc), 32'd255);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("wrap_fwd", 32'(pc), 32'd0);

    // BZ not taken / taken
    do_reset();
    step(1'b0, 1'b1, 16'h1003, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("bz_nt", 32'(pc), 32'h1);
    do_reset();
    step(1'b0, 1'b1, 16'h1003, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bz_t", 32'(pc), 32'h4);

    // HALT holds with imem_ready toggling, reset releases it
    do_reset();
    step(1'b0, 1'b1, 16'h4000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'(i % 2), 16'h8001, 1'b1, 1'b1);
      chk("halt_state", 32'(state), 32'h0);
      chk("halt_flag", 32'(halted), 32'h1);
    end
    chk("halt_pc", 32'(pc), 32'h1);
    do_reset();
    chk("unhalt_state", 32'(state), 32'h1);
    chk("unhalt_pc", 32'(pc), RESET_PC);
    chk("unhalt_flag", 32'(halted), 32'h0);

    // imem stall in FETCH
    step(1'b0, 1'b1, 16'h3ABC, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h9999, 1'b0, 1'b0);
      chk("stall_state", 32'(state), 32'h1);
      chk("stall_pc", 32'(pc), 32'h1);
      chk("stall_inst", 32'(inst), 32'h3ABC);
    end

    // Reset during EXEC2
    step(1'b0, 1'b1, 16'hE045, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("rst_ex2_pre", 32'(state), 32'h4);
    do_reset();
    chk("rst_ex2_state", 32'(state), 32'h1);
    chk("rst_ex2_inst", 32'(inst), 32'h0);

    // Random instruction streams
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2) || (halt_cnt > 6);
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      z  = 1'($urandom_range(0, 1));
      d  = 16'($urandom);
      if ($urandom_range(0, 9) < 3) d[15:12] = 4'($urandom_range(0, 1));
      step(r, ir, d, dr, z);
      halt_cnt = (m_ph == 3) ? halt_cnt + 1 : 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
